// File: rtl/fft_twiddle_sequencer_if.sv
// Butterfly job handshake between the FFT sequencer and the butterfly datapath.
// The sequencer drives jobs through master; the datapath accepts them through slave.
interface fft_twiddle_sequencer_if #(
    parameter int N = 32
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2($clog2(N));

    logic          bf_valid;
    logic          bf_ready;
    logic [AW-1:0] bf_addr_a;
    logic [AW-1:0] bf_addr_b;
    logic [SW-1:0] bf_stage;

    modport master (
        output bf_valid,
        output bf_addr_a,
        output bf_addr_b,
        output bf_stage,
        input  bf_ready
    );

    modport slave (
        input  bf_valid,
        input  bf_addr_a,
        input  bf_addr_b,
        input  bf_stage,
        output bf_ready
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with a 1-cycle twiddle ROM.
// Define FFT_SEQ_INVERSE_EN to add the `inverse` port (conjugate twiddle addressing).
module fft_twiddle_sequencer #(
    parameter int N         = 32,
    parameter int STAGE_GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic                 inverse,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] rom_addr,
    fft_twiddle_sequencer_if.master bf
);
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int SW    = $clog2(LOG2N);
    localparam int CW    = AW - 1;
    localparam int GW    = $clog2(STAGE_GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] bf_cnt;
    logic [SW-1:0] stage_cnt;
    logic [GW-1:0] gap_cnt;
    logic          valid_q;
    logic [AW-1:0] a_q;
    logic [AW-1:0] b_q;
    logic [AW-1:0] tw_q;
    logic [SW-1:0] stage_q;
`ifdef FFT_SEQ_INVERSE_EN
    logic          inv_q;
`endif

    logic          job_done;
    logic          adv;
    logic          last_bf;
    logic          last_stage;
    logic          gap_over;
    logic [AW-1:0] half;
    logic [AW-1:0] mask;
    logic [AW-1:0] pos;
    logic [AW-1:0] a_cur;
    logic [AW-1:0] b_cur;
    logic [AW-1:0] tw_cur;
    logic [AW-1:0] tw_sel;
    logic [SW-1:0] sh;

    // The held job is retired either by acceptance or by never having been issued.
    assign job_done   = !valid_q || bf.bf_ready;
    assign adv        = (state == S_RUN) && job_done;
    assign last_bf    = bf_cnt == CW'(N/2 - 1);
    assign last_stage = stage_cnt == SW'(LOG2N - 1);
    assign gap_over   = job_done && (gap_cnt == GW'(STAGE_GAP));

    assign bf.bf_valid  = valid_q;
    assign bf.bf_addr_a = a_q;
    assign bf.bf_addr_b = b_q;
    assign bf.bf_stage  = stage_q;

    always_comb begin
        half   = AW'(1) << stage_cnt;
        mask   = half - AW'(1);
        pos    = AW'(bf_cnt) & mask;
        a_cur  = ((AW'(bf_cnt) & ~mask) << 1) | pos;
        b_cur  = a_cur + half;
        sh     = SW'(LOG2N - 1) - stage_cnt;
        tw_cur = pos << sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (adv && last_bf) state_nxt = last_stage ? S_FLUSH : S_GAP;
            S_GAP:   if (gap_over) state_nxt = S_RUN;
            S_FLUSH: if (job_done) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        tw_sel = adv ? tw_cur : tw_q;
        unique case (1'b1)
            state == S_RUN,
            state == S_GAP,
            state == S_FLUSH: busy = 1'b1;
            state == S_DONE:  done = 1'b1;
            default: ;
        endcase
`ifdef FFT_SEQ_INVERSE_EN
        rom_addr = inv_q ? AW'(0) - tw_sel : tw_sel;
`else
        rom_addr = tw_sel;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_cnt    <= '0;
            stage_cnt <= '0;
            gap_cnt   <= '0;
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            tw_q      <= '0;
            stage_q   <= '0;
`ifdef FFT_SEQ_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                bf_cnt    <= '0;
                stage_cnt <= '0;
`ifdef FFT_SEQ_INVERSE_EN
                inv_q     <= inverse;
`endif
            end
            if (adv) begin
                valid_q <= 1'b1;
                a_q     <= a_cur;
                b_q     <= b_cur;
                tw_q    <= tw_cur;
                stage_q <= stage_cnt;
                bf_cnt  <= last_bf ? '0 : bf_cnt + CW'(1);
                if (last_bf) begin
                    stage_cnt <= last_stage ? '0 : stage_cnt + SW'(1);
                end
            end else if (bf.bf_ready) begin
                valid_q <= 1'b0;
            end
            // Gap cycles start counting on the cycle the stage's last job retires.
            if (state != S_GAP) begin
                gap_cnt <= '0;
            end else if (job_done) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Scoreboard bench for fft_twiddle_sequencer: golden job list per transform,
// monitor pops and compares every accepted job against a modelled twiddle ROM.
module tb_fft_twiddle_sequencer;
    localparam int N     = 32;
    localparam int SG    = 2;
    localparam int LOG2N = 5;
    localparam int AW    = 5;
    localparam int NJOB  = N / 2 * LOG2N;

    typedef struct {
        int k;
        int s;
        int a;
        int b;
        int tw;
    } job_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [15:0]   twiddle;
`ifdef FFT_SEQ_INVERSE_EN
    logic          inverse = 1'b0;
`endif

    fft_twiddle_sequencer_if #(.N(N)) bf ();

    fft_twiddle_sequencer #(
        .N(N),
        .STAGE_GAP(SG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
`ifdef FFT_SEQ_INVERSE_EN
        .inverse(inverse),
`endif
        .busy(busy),
        .done(done),
        .rom_addr(rom_addr),
        .bf(bf)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] rom_val(input int k);
        return 16'(k * 37 + 11);
    endfunction

    always @(posedge clk) twiddle <= rom_val(int'(rom_addr));

    job_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_cnt   = 0;
    int   acc_cnt    = 0;
    int   stall_seen = 0;
    int   gaps_seen  = 0;
    int   mode       = 0;
    int   stall_left = 0;
    bit   chk_gap    = 1'b0;

    task automatic check(input bit ok, input string name,
                         input string act, input string req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%s required=%s", name, act, req);
        end
    endtask

    task automatic push_transform(input bit inv);
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                job_t j;
                int   half;
                int   t;
                half = 2 ** s;
                t    = (k % half) * (N / (2 * half));
                j.k  = k;
                j.s  = s;
                j.a  = (k / half) * 2 * half + (k % half);
                j.b  = j.a + half;
                j.tw = inv ? (N - t) % N : t;
                exp_q.push_back(j);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_to_done(input int d0, input int a0, input string tag);
        for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check(done_cnt == d0 + 1, {tag, "_done_once"},
              $sformatf("%0d", done_cnt - d0), "1");
        check(exp_q.size() == 0 && acc_cnt - a0 == NJOB, {tag, "_job_count"},
              $sformatf("acc=%0d left=%0d", acc_cnt - a0, exp_q.size()),
              $sformatf("acc=%0d left=0", NJOB));
    endtask

    function automatic bit outs_zero();
        return !busy && !done && !bf.bf_valid && bf.bf_addr_a == 0 &&
               bf.bf_addr_b == 0 && bf.bf_stage == 0 && rom_addr == 0;
    endfunction

    // bf_ready driver: constant, random, or a 3-cycle stall on stage 2 b=5.
    initial begin
        bf.bf_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: bf.bf_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bf.bf_valid && bf.bf_stage == 2 && bf.bf_addr_a == 9 &&
                        stall_left > 0) begin
                        bf.bf_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bf.bf_ready = 1'b1;
                    end
                end
                default: bf.bf_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop, stall stability, stage gap, done/busy.
    initial begin
        bit        stalled_prev = 1'b0;
        bit        gap_arm      = 1'b0;
        int        lowrun       = 0;
        int        pa, pb, ps;
        int        ptw;
        job_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled_prev = 1'b0;
                gap_arm      = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check(bf.bf_valid && bf.bf_addr_a == pa && bf.bf_addr_b == pb &&
                          bf.bf_stage == ps && twiddle == ptw, "stall_hold",
                          $sformatf("v=%0b a=%0d b=%0d s=%0d tw=%0h", bf.bf_valid,
                                    bf.bf_addr_a, bf.bf_addr_b, bf.bf_stage, twiddle),
                          $sformatf("v=1 a=%0d b=%0d s=%0d tw=%0h", pa, pb, ps, ptw));
                end
                stalled_prev = bf.bf_valid && !bf.bf_ready;
                pa  = int'(bf.bf_addr_a);
                pb  = int'(bf.bf_addr_b);
                ps  = int'(bf.bf_stage);
                ptw = int'(twiddle);
                if (mode == 2 && bf.bf_valid && !bf.bf_ready &&
                    bf.bf_stage == 2 && bf.bf_addr_a == 9) begin
                    stall_seen++;
                    check(rom_addr == 4, "stall_rom_addr",
                          $sformatf("%0d", rom_addr), "4");
                end
                if (done) begin
                    done_cnt++;
                    check(!busy, "busy_at_done", $sformatf("%0b", busy), "0");
                end
                if (gap_arm) begin
                    if (!bf.bf_valid) begin
                        lowrun++;
                    end else begin
                        gaps_seen++;
                        gap_arm = 1'b0;
                        check(lowrun == SG + 1, "stage_gap",
                              $sformatf("%0d", lowrun), $sformatf("%0d", SG + 1));
                    end
                end
                if (bf.bf_valid && bf.bf_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_job",
                              $sformatf("a=%0d s=%0d", bf.bf_addr_a, bf.bf_stage), "none");
                    end else begin
                        e = exp_q.pop_front();
                        check(bf.bf_addr_a == e.a && bf.bf_addr_b == e.b &&
                              bf.bf_stage == e.s && twiddle == rom_val(e.tw), "job",
                              $sformatf("a=%0d b=%0d s=%0d tw=%0h", bf.bf_addr_a,
                                        bf.bf_addr_b, bf.bf_stage, twiddle),
                              $sformatf("a=%0d b=%0d s=%0d tw=%0h", e.a, e.b, e.s,
                                        rom_val(e.tw)));
                        if (chk_gap && e.k == N / 2 - 1 && e.s < LOG2N - 1) begin
                            gap_arm = 1'b1;
                            lowrun  = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        int a0;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check(outs_zero(), "reset_outputs", $sformatf("busy=%0b v=%0b rom=%0d",
              busy, bf.bf_valid, rom_addr), "all zero");
        rst_n = 1'b1;

        // Constant ready: latency, consecutive jobs, stage gaps.
        mode = 0;
        chk_gap = 1'b1;
        d0 = done_cnt;
        a0 = acc_cnt;
        push_transform(1'b0);
        pulse_start();
        check(busy && !bf.bf_valid, "start_latency_1",
              $sformatf("busy=%0b v=%0b", busy, bf.bf_valid), "busy=1 v=0");
        @(posedge clk);
        #1;
        check(bf.bf_valid && bf.bf_addr_a == 0 && bf.bf_addr_b == 1, "start_latency_2",
              $sformatf("v=%0b a=%0d b=%0d", bf.bf_valid, bf.bf_addr_a, bf.bf_addr_b),
              "v=1 a=0 b=1");
        run_to_done(d0, a0, "const");
        check(gaps_seen == LOG2N - 1, "gap_count",
              $sformatf("%0d", gaps_seen), $sformatf("%0d", LOG2N - 1));
        chk_gap = 1'b0;

        // Three-cycle stall on stage 2 b=5.
        mode = 2;
        stall_left = 3;
        d0 = done_cnt;
        a0 = acc_cnt;
        push_transform(1'b0);
        pulse_start();
        run_to_done(d0, a0, "stall");
        check(stall_seen == 3, "stall_cycles", $sformatf("%0d", stall_seen), "3");

        // Random ready with a start pulse while busy in stage 1.
        mode = 1;
        d0 = done_cnt;
        a0 = acc_cnt;
        push_transform(1'b0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            found = bf.bf_valid && bf.bf_stage == 1;
        end
        check(found, "reach_stage1", $sformatf("%0b", found), "1");
        pulse_start();
        run_to_done(d0, a0, "busy_start");

        // Async reset at stage 3 b=7.
        push_transform(1'b0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            found = bf.bf_valid && bf.bf_stage == 3 && bf.bf_addr_a == 7;
        end
        check(found, "reach_stage3_b7", $sformatf("%0b", found), "1");
        #2 rst_n = 1'b0;
        #1;
        check(outs_zero(), "abort_outputs", $sformatf("busy=%0b v=%0b a=%0d rom=%0d",
              busy, bf.bf_valid, bf.bf_addr_a, rom_addr), "all zero");
        d0 = done_cnt;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check(done_cnt == d0 && !busy, "abort_no_done",
              $sformatf("done=%0d busy=%0b", done_cnt - d0, busy), "done=0 busy=0");

        // Clean transform after the abort.
        d0 = done_cnt;
        a0 = acc_cnt;
        push_transform(1'b0);
        pulse_start();
        run_to_done(d0, a0, "after_reset");

`ifdef FFT_SEQ_INVERSE_EN
        inverse = 1'b1;
        d0 = done_cnt;
        a0 = acc_cnt;
        push_transform(1'b1);
        pulse_start();
        inverse = 1'b0;
        run_to_done(d0, a0, "inverse");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
Control sequencer for an in-place radix-2 DIT FFT.
- On `start`, walks every stage and butterfly.
- Drives the twiddle ROM read address and the butterfly operand addresses.
- Presents each butterfly job to the datapath with a valid/ready handshake.
- Accounts for the ROM's 1-cycle registered read so that `bf_valid` lines up with the ROM's `twiddle` output.

Parameters:
- N, 32, FFT points. Power of 2, ≥4. Equals the ROM depth.
- STAGE_GAP, 2, idle cycles inserted after the last accepted butterfly of a stage before the next stage issues. Covers butterfly write-back latency. 0 is legal.
- LOG2N (localparam), $clog2(N), number of stages.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transform when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final butterfly is accepted
- rom_addr  out  $clog2(N)  twiddle ROM read_address (combinational)
- bf_valid  out  1  butterfly job valid; ROM twiddle output valid this cycle
- bf_ready  in  1  datapath accepts job
- bf_addr_a  out  $clog2(N)  upper operand address
- bf_addr_b  out  $clog2(N)  lower operand address
- bf_stage  out  $clog2(LOG2N)  stage of the presented job

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters 0. Async assert aborts any transform mid-operation; no done pulse.
- FSM states:
  - IDLE → RUN on start.
  - RUN → GAP after the last issue of a stage (s<LOG2N-1).
  - RUN → FLUSH after the last issue of stage LOG2N-1.
  - GAP → RUN after the last job of the stage is accepted and STAGE_GAP cycles have elapsed.
  - FLUSH → DONE when the final job is accepted.
  - DONE → IDLE after one cycle; done=1 in DONE.
- start outside IDLE is ignored.
- Indexing: stage s=0..LOG2N-1, butterfly b=0..N/2-1 (b inner). Then:
  - half=2^s, pos=b&(half-1), grp=b>>s
  - a=grp*2*half+pos, b_addr=a+half
  - tw=pos<<(LOG2N-1-s)
  - All values are unsigned and fit in $clog2(N) bits.
- Issue/advance: adv = RUN && (!bf_valid || bf_ready).
  - On adv: counters increment. bf_addr_a, bf_addr_b and bf_stage register the issued job. bf_valid←1 next cycle.
  - When not issuing but bf_ready: bf_valid←0.
- rom_addr = adv ? tw(current counter) : tw(held job).
  - The ROM has no enable, so during a stall it keeps re-reading the held job's address.
  - The twiddle therefore stays stable while bf_valid && !bf_ready.
  - Latency start→first bf_valid: 2 cycles (IDLE→RUN, then the ROM register).
- Outputs hold stable while bf_valid && !bf_ready.
- Stage barrier:
  - No issue for stage s+1 until stage s's last job is accepted.
  - Then STAGE_GAP further cycles elapse.
  - rom_addr in GAP/FLUSH/IDLE = tw(held job).
- Total jobs per transform: N/2*LOG2N (80 at N=32). No job is dropped or duplicated under any bf_ready pattern.

Optional Feature:
FFT_SEQ_INVERSE_EN:
- Defined:
  - Adds input port `inverse` (1 bit), sampled on the accepted start and held for the whole transform.
  - When set, rom_addr = (N - tw) mod N, i.e. conjugate twiddle W^-k. tw=0 maps to 0.
- Undefined:
  - The port does not exist.
  - Forward twiddles only.

Test Plan:
- N=32, bf_ready=1 constantly, start pulse:
  - 80 jobs on consecutive cycles within a stage.
  - Stage 0: tw=0, pairs (0,1),(2,3)…
  - Stage 4: tw=b, pairs (b,b+16).
  - STAGE_GAP=2 idle cycles between stages.
  - done pulses exactly once; busy falls with it.
- Stall on job stage 2 b=5 (a=9, b_addr=13, tw=4) for 3 cycles (bf_ready=0):
  - bf_addr_a/b and ROM twiddle stay stable at tw=4.
  - The job is accepted once; the next job is b=6 (a=10, tw=8).
- Random bf_ready (50%):
  - Scoreboard matches the golden address sequence (80 jobs, no dup/drop).
  - Every accepted twiddle equals ROM[tw].
- start pulsed while busy mid-stage 1: ignored; sequence and done count unchanged.
- rst_n asserted at stage 3 b=7:
  - Outputs zero immediately; no done.
  - A new start runs a full clean 80-job transform.
- With FFT_SEQ_INVERSE_EN, inverse=1, stage 4 b=3: rom_addr=29; b=0: rom_addr=0.
